// File: rtl/pool_buf_reader.sv
// pool_buf_reader: walks a stored ch/row/col feature map out of BRAM and presents it
// as a valid/ready byte stream with row, channel and frame markers.
module pool_buf_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [4:0]        ifmap_size_i,
  input  logic [5:0]        ifmap_ch_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rden_o,
  output logic [ADDR_W-1:0] rdptr_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              row_last_o,
  output logic              ch_last_o,
  output logic              frame_last_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [4:0]        s_q, col_q, row_q;
  logic [5:0]        c_q, ch_q;
  logic [ADDR_W-1:0] base_q, idx_q;
  logic              inflight_q;
  logic [2:0]        mk_q;
  logic [DATA_W+2:0] mem_q [FIFO_DEPTH];
  logic [DATA_W+2:0] head;
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic              accept, row_end, ch_end, frame_end, issue, pop;
  assign accept    = state_q == IDLE && start_i;
  assign row_end   = col_q == s_q - 5'd1;
  assign ch_end    = row_end && row_q == s_q - 5'd1;
  assign frame_end = ch_end && ch_q == c_q - 6'd1;
  // Credit: a read may only issue if its data is guaranteed a FIFO slot.
  assign issue     = state_q == RUN && (cnt_q + {{AW{1'b0}}, inflight_q}) < (AW+1)'(FIFO_DEPTH);
  assign pop       = valid_o && ready_i;
  assign head      = mem_q[rd_q];
  assign busy_o       = state_q == RUN || state_q == DRAIN;
  assign done_o       = state_q == DONE;
  assign rden_o       = issue;
  assign rdptr_o      = base_q + idx_q;
  assign valid_o      = cnt_q != '0;
  assign data_o       = valid_o ? head[DATA_W-1:0] : '0;
  assign row_last_o   = valid_o && head[DATA_W];
  assign ch_last_o    = valid_o && head[DATA_W+1];
  assign frame_last_o = valid_o && head[DATA_W+2];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !start_i ? IDLE : (ifmap_size_i != '0 && ifmap_ch_i != '0) ? RUN : DONE;
      RUN:     state_d = (issue && frame_end) ? DRAIN : RUN;
      DRAIN:   state_d = (cnt_q == '0 && !inflight_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= '0;
      c_q        <= '0;
      base_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      ch_q       <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
      mk_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        s_q    <= ifmap_size_i;
        c_q    <= ifmap_ch_i;
        base_q <= base_addr_i;
        col_q  <= '0;
        row_q  <= '0;
        ch_q   <= '0;
        idx_q  <= '0;
      end else if (issue) begin
        col_q <= row_end ? 5'd0 : col_q + 5'd1;
        row_q <= ch_end ? 5'd0 : row_end ? row_q + 5'd1 : row_q;
        ch_q  <= ch_end ? ch_q + 6'd1 : ch_q;
        idx_q <= idx_q + 1'b1;
        mk_q  <= {frame_end, ch_end, row_end};
      end
      if (inflight_q) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, inflight_q} - {{AW{1'b0}}, pop};
    end
  end
  // Storage needs no reset: outputs are gated by the count.
  always_ff @(posedge clk) begin
    if (inflight_q) mem_q[wr_q] <= {mk_q, rdata_i};
  end
endmodule
